// File: rtl/mc_pkg.sv
// Shared encodings for the motor-control word and the H-bridge FSM.
// Field positions follow the navigation controller's 5-bit word layout.
package mc_pkg;

  localparam logic [1:0] DIR_FWD = 2'b00;
  localparam logic [1:0] DIR_NEU = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  localparam int MC_DIR_LSB = 0;
  localparam int MC_DIR_MSB = 1;
  localparam int MC_PWR_LSB = 2;
  localparam int MC_PWR_MSB = 4;

  typedef enum logic [1:0] {
    ST_COAST = 2'b00,
    ST_FWD   = 2'b01,
    ST_REV   = 2'b10,
    ST_DEAD  = 2'b11
  } mc_state_e;

endpackage

// File: rtl/mc_pwm_gen.sv
// Free-running PWM counter with period tick and registered duty compare.
// The compare uses next-cycle values so PWM lines up with the counter.
module mc_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [2:0] code,
  output logic       boundary,
  output logic       PERIOD_TICK,
  output logic       PWM
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cnt_nx;
  logic [PWM_BITS:0]   thr;

  assign cnt_nx   = cnt + PWM_BITS'(1);
  assign boundary = &cnt;
  assign thr      = ((PWM_BITS+1)'(code) + (PWM_BITS+1)'(1))
                    << (PWM_BITS - 3);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= '0;
      PERIOD_TICK <= 1'b0;
      PWM         <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      PERIOD_TICK <= boundary;
      PWM         <= en && ({1'b0, cnt_nx} < thr);
    end
  end

endmodule

// File: rtl/mc_hbridge_driver.sv
// Motor-word decoder for one H-bridge with forced dead time on drive exit.
// Define MC_SOFTSTART_EN for a stepped duty ramp after entering a drive state.
module mc_hbridge_driver
  import mc_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DEAD_CYCLES  = 1000,
  parameter int RAMP_PERIODS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] MC,
  output logic       IN_A,
  output logic       IN_B,
  output logic       PWM,
  output logic [1:0] STATE,
  output logic       PERIOD_TICK
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  if (PWM_BITS < 3 || DEAD_CYCLES < 1 || RAMP_PERIODS < 1) begin : g_bad
    $error("mc_hbridge_driver: illegal parameter set");
  end

  mc_state_e     state;
  mc_state_e     state_nx;
  logic [4:0]    mc_q;
  logic [4:0]    cmd_q;
  logic [4:0]    cmd_nx;
  logic [1:0]    dir_nx;
  logic [2:0]    code_nx;
  logic [DW-1:0] dead_cnt;
  logic          dead_done;
  logic          boundary;
  logic          drive_nx;
  logic          in_a_nx;
  logic          in_b_nx;

  // Commands only take effect at a period boundary to keep PWM glitch-free
  assign cmd_nx    = boundary ? mc_q : cmd_q;
  assign dir_nx    = cmd_nx[MC_DIR_MSB:MC_DIR_LSB];
  assign dead_done = dead_cnt == DW'(DEAD_CYCLES - 1);
  assign STATE     = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mc_q     <= {3'b000, DIR_NEU};
      cmd_q    <= {3'b000, DIR_NEU};
      dead_cnt <= '0;
    end else begin
      mc_q     <= MC;
      cmd_q    <= cmd_nx;
      if (state == ST_DEAD && !dead_done)
        dead_cnt <= dead_cnt + DW'(1);
      else
        dead_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_COAST;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_COAST: begin
        if (boundary && dir_nx == DIR_FWD)
          state_nx = ST_FWD;
        else if (boundary && dir_nx == DIR_REV)
          state_nx = ST_REV;
      end
      ST_FWD: begin
        if (boundary && dir_nx != DIR_FWD)
          state_nx = ST_DEAD;
      end
      ST_REV: begin
        if (boundary && dir_nx != DIR_REV)
          state_nx = ST_DEAD;
      end
      ST_DEAD: begin
        if (dead_done)
          state_nx = ST_COAST;
      end
      default: state_nx = ST_COAST;
    endcase
  end

  always_comb begin
    in_a_nx  = 1'b0;
    in_b_nx  = 1'b0;
    drive_nx = 1'b0;
    unique case (1'b1)
      state_nx == ST_FWD: begin
        in_a_nx  = 1'b1;
        drive_nx = 1'b1;
      end
      state_nx == ST_REV: begin
        in_b_nx  = 1'b1;
        drive_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IN_A <= 1'b0;
      IN_B <= 1'b0;
    end else begin
      IN_A <= in_a_nx;
      IN_B <= in_b_nx;
    end
  end

`ifdef MC_SOFTSTART_EN
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  logic [2:0]    app_q;
  logic [2:0]    tgt;
  logic [RW-1:0] ramp_q;
  logic [RW-1:0] ramp_nx;

  assign tgt = cmd_nx[MC_PWR_MSB:MC_PWR_LSB];

  // Duty restarts from code 0 whenever the bridge was not already driving
  always_comb begin
    code_nx = app_q;
    ramp_nx = ramp_q;
    if (!drive_nx || state == ST_COAST) begin
      code_nx = 3'd0;
      ramp_nx = '0;
    end else if (boundary) begin
      if (ramp_q == RW'(RAMP_PERIODS - 1)) begin
        ramp_nx = '0;
        if (app_q < tgt)
          code_nx = app_q + 3'd1;
        else if (app_q > tgt)
          code_nx = app_q - 3'd1;
      end else begin
        ramp_nx = ramp_q + RW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      app_q  <= 3'd0;
      ramp_q <= '0;
    end else begin
      app_q  <= code_nx;
      ramp_q <= ramp_nx;
    end
  end
`else
  assign code_nx = cmd_nx[MC_PWR_MSB:MC_PWR_LSB];
`endif

  mc_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .CLK         (CLK),
    .RST         (RST),
    .en          (drive_nx),
    .code        (code_nx),
    .boundary    (boundary),
    .PERIOD_TICK (PERIOD_TICK),
    .PWM         (PWM)
  );

endmodule

// File: tb/tb_mc_hbridge_driver.sv
// Randomised bench for mc_hbridge_driver against a period-level model.
// Uses a 16-clock PWM period and a 5-clock dead time.
module tb_mc_hbridge_driver;

  localparam int PB  = 4;
  localparam int DC  = 5;
  localparam int PER = 16;

  localparam int M_CO = 0;
  localparam int M_FW = 1;
  localparam int M_RV = 2;
  localparam int M_DE = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] MC  = 5'b000_01;
  logic       IN_A;
  logic       IN_B;
  logic       PWM;
  logic [1:0] STATE;
  logic       PERIOD_TICK;

  int total = 0;
  int bad   = 0;

  int         k;
  int         mode;
  int         code;
  int         dstart;
  logic [4:0] last_mc;

  mc_hbridge_driver #(
    .PWM_BITS     (PB),
    .DEAD_CYCLES  (DC),
    .RAMP_PERIODS (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .MC          (MC),
    .IN_A        (IN_A),
    .IN_B        (IN_B),
    .PWM         (PWM),
    .STATE       (STATE),
    .PERIOD_TICK (PERIOD_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    mode    = M_CO;
    code    = 0;
    dstart  = 0;
    last_mc = 5'b000_01;
  endtask

  // k counts clock edges since reset release; periods begin where k%16==0
  // and obey the word that was sampled on the edge just before.
  task automatic step(input logic [4:0] mc);
    logic [4:0] src;
    int         ph;
    int         d;
    bit         drv;
    MC = mc;
    @(posedge CLK);
    k++;
    src     = last_mc;
    last_mc = mc;
    ph      = k % PER;
    d       = int'(src[1:0]);
    if (mode == M_DE) begin
      if (k - dstart == DC) mode = M_CO;
    end else if (ph == 0) begin
      code = int'(src[4:2]);
      if (mode == M_CO) begin
        if (d == 0) mode = M_FW;
        else if (d == 2) mode = M_RV;
      end else if ((mode == M_FW && d != 0) ||
                   (mode == M_RV && d != 2)) begin
        mode   = M_DE;
        dstart = k;
      end
    end
    drv = (mode == M_FW) || (mode == M_RV);
    #1;
    chk("in_a",  8'(IN_A), 8'(mode == M_FW));
    chk("in_b",  8'(IN_B), 8'(mode == M_RV));
    chk("pwm",   8'(PWM), 8'(drv && ph < (code + 1) * (PER / 8)));
    chk("tick",  8'(PERIOD_TICK), 8'(ph == 0));
    chk("state", 8'(STATE), 8'(mode));
    chk("shoot", 8'(IN_A & IN_B), 8'd0);
  endtask

  task automatic run(input logic [4:0] mc, input int n);
    for (int i = 0; i < n; i++) step(mc);
  endtask

  task automatic chk_low(input string tag);
    chk({tag, "_a"},  8'(IN_A), 8'd0);
    chk({tag, "_b"},  8'(IN_B), 8'd0);
    chk({tag, "_p"},  8'(PWM), 8'd0);
    chk({tag, "_s"},  8'(STATE), 8'd0);
    chk({tag, "_t"},  8'(PERIOD_TICK), 8'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_low("rst");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();

    run(5'b000_01, 100);
    run(5'b000_00, 40);
    run(5'b111_00, 40);
    run(5'b011_00, 40);
    run(5'b011_10, 70);

    for (int i = 0; i < 32; i++)
      run((i % 2 == 0) ? 5'b010_00 : 5'b010_01, 3);

    for (int i = 0; i < 20; i++)
      run(5'($urandom), int'($urandom_range(1, 40)));

    run(5'b111_10, 80);
    chk("pre_rst_pwm", 8'(PWM), 8'd1);
    chk("pre_rst_st",  8'(STATE), 8'(M_RV));
    #3;
    RST = 1'b1;
    #1;
    chk_low("async");
    @(posedge CLK);
    #1;
    chk_low("hold");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    run(5'b111_10, 10);
    run(5'b101_00, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_hbridge_driver.md
Name: mc_hbridge_driver

Overview:
- Receiving end of the 5-bit motor-control word produced by the navigation direction controller.
- Decodes the word (bits 1:0 direction, bits 4:2 power) into H-bridge drive signals: IN_A, IN_B and a PWM enable.
- Inserts a mandatory coast/dead-time interval on every exit from a drive state, so the bridge never reverses directly.
- One instance per motor; the top level instantiates two (right side on MC1, left side on MC2).

Parameters:
- PWM_BITS, 8: PWM counter width; period = 2^PWM_BITS clocks.
- DEAD_CYCLES, 1000: clocks held in dead time (all outputs low) after leaving a drive state; must be ≥1.
- RAMP_PERIODS, 4: PWM periods per soft-start step. Used only when MC_SOFTSTART_EN is defined.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- MC  in  5  motor word. [1:0]: 00 forward, 01 neutral, 10 reverse, 11 treated as neutral. [4:2]: power code.
- IN_A  out  1  bridge high-side A select.
- IN_B  out  1  bridge high-side B select.
- PWM  out  1  bridge enable, pulse-width modulated.
- STATE  out  2  current FSM state, for LED debug.
- PERIOD_TICK  out  1  one-clock pulse at each PWM period boundary.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-high.
- Reset values: IN_A=0, IN_B=0, PWM=0, STATE=COAST(00), PERIOD_TICK=0. PWM counter=0, dead counter=0, latched command = neutral/code 0.
- Input register: MC is registered every clock into mc_q. No synchroniser is needed; the source is in the same clock domain.
- PWM counter: free-running, PWM_BITS wide, wraps from all-ones to 0.
  - Boundary = counter == all-ones. PERIOD_TICK is asserted in the cycle after the boundary, aligned with counter==0.
- Command latching: mc_q is latched into the active command only at a boundary. Mid-period changes of MC have no effect until the next boundary, so there are no PWM glitches.
- Duty: threshold = (code+1) << (PWM_BITS-3), PWM_BITS+1 bits wide.
  - PWM = (counter < threshold) in a drive state, registered.
  - Code 0 gives 12.5% duty; code 7 gives 100% (threshold = 2^PWM_BITS, always high).
- FSM states: COAST=00, FWD=01, REV=10, DEAD=11. All outputs are registered.
  - COAST: IN_A=IN_B=PWM=0. At a boundary: command fwd → FWD, rev → REV, otherwise stay.
  - FWD: IN_A=1, IN_B=0, PWM per duty. At a boundary: fwd → stay with the new duty; any other command → DEAD.
  - REV: IN_A=0, IN_B=1, PWM per duty. At a boundary: rev → stay; any other command → DEAD.
  - DEAD: IN_A=IN_B=PWM=0. The dead counter counts from 0; when it reaches DEAD_CYCLES-1 → COAST and the counter clears.
- Minimum reversal time: reversal therefore always passes DEAD → COAST, taking at least DEAD_CYCLES clocks plus the wait for the next boundary.
- Simultaneous events: a boundary occurring in DEAD is ignored; a command change during DEAD is ignored.
- Reset mid-operation: all outputs go low immediately (asynchronous) and the FSM returns to COAST.

Optional Feature:
- Macro: MC_SOFTSTART_EN.
- Defined:
  - A 3-bit applied_code register drives the duty instead of the latched code.
  - Entering FWD/REV from COAST sets applied_code=0.
  - Every RAMP_PERIODS boundaries, applied_code moves one step toward the latched code, both up and down.
  - Entering DEAD or COAST clears applied_code to 0.
- Undefined: applied_code = latched code at each boundary, with no ramp logic or ramp counter.

Decomposition:
- Package mc_pkg holds:
  - direction codes DIR_FWD/DIR_NEU/DIR_REV;
  - state encodings ST_COAST/ST_FWD/ST_REV/ST_DEAD;
  - field positions MC_DIR_LSB/MSB and MC_PWR_LSB/MSB.
- Sub-module mc_pwm_gen contains the free-running counter, boundary/tick generation and the registered duty comparator. The FSM and dead-time logic stay in mc_hbridge_driver.

Test Plan:
All scenarios use PWM_BITS=4 (16-clock period) and DEAD_CYCLES=5.
1. Reset then MC=5'b000_01 held 100 clocks → IN_A=IN_B=PWM=0 throughout, STATE=00, PERIOD_TICK every 16 clocks.
2. MC=5'b000_00 → FWD after the next boundary (IN_A=1, IN_B=0); PWM high 2 of 16 clocks. Change to MC=5'b111_00 → PWM constantly high from the following period.
3. Running FWD, code 3; MC changes to 5'b011_10 mid-period → FWD holds until the boundary, then DEAD for exactly 5 clocks with all outputs low, then COAST, then REV at the next boundary with PWM high 8 of 16.
4. MC toggles fwd/neutral every 3 clocks, never stable at a boundary → outputs change only at boundaries; no cycle ever has IN_A=IN_B=1.
5. Assert RST for 1 clock while in REV with PWM high → outputs go low in the same cycle (asynchronous); STATE=00 after release.
6. With MC_SOFTSTART_EN and RAMP_PERIODS=2, MC=5'b111_00 from COAST → applied code 0,1,…,7 stepping every 2 periods; duty 2,4,…,16 of 16.
